// File: rtl/soc_spram_arbiter_pkg.sv
// soc_spram_arb_pkg: FSM state encoding and default widths shared by the SPRAM arbiter slice.
package soc_spram_arb_pkg;
    localparam int AW_DEF = 15;
    localparam int DW_DEF = 32;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK = 1'b1;
endpackage

// File: rtl/soc_spram_arbiter_if.sv
// soc_spram_arbiter_if: per-port request bundle between requesters (master) and the arbiter (slave).
interface soc_spram_arbiter_if
    import soc_spram_arb_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic [AW*N_PORTS-1:0] req_addr;
    logic [DW*N_PORTS-1:0] req_wdata;
    logic [(DW/8)*N_PORTS-1:0] req_wmsk;
    logic [N_PORTS-1:0] req_we;
    logic [N_PORTS-1:0] req_valid;
    logic [N_PORTS-1:0] req_ready;
    logic [DW-1:0] req_rdata;
    modport master (
        output req_addr, req_wdata, req_wmsk, req_we, req_valid,
        input req_ready, req_rdata
    );
    modport slave (
        input req_addr, req_wdata, req_wmsk, req_we, req_valid,
        output req_ready, req_rdata
    );
endinterface

// File: rtl/soc_spram_arbiter_arb_rr_pick.sv
// arb_rr_pick: combinational N-way picker; round-robin from last+1, or lowest index wins
// when SOC_SPRAM_ARB_FIXED_PRIO_EN is defined.
module arb_rr_pick
    import soc_spram_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [LW-1:0] idx,
    output logic          vld
);
`ifdef SOC_SPRAM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last;
    assign vld = |req;
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[k]) idx = LW'(k);
    end
`else
    logic [LW-1:0] cand;
    always_comb begin
        idx = '0;
        vld = 1'b0;
        cand = '0;
        for (int k = 1; k <= N; k++) begin
            cand = LW'((int'(last) + k) % N);
            if (!vld && req[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
    end
`endif
endmodule

// File: rtl/soc_spram_arbiter.sv
// soc_spram_arbiter: N-port round-robin arbiter onto a single-port SRAM, two cycles per access.
// Define SOC_SPRAM_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module soc_spram_arbiter
    import soc_spram_arb_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    soc_spram_arbiter_if.slave  bus,
    output logic [AW-1:0]       spram_addr,
    output logic [DW-1:0]       spram_wdata,
    output logic [DW/8-1:0]     spram_wmsk,
    output logic                spram_we,
    input  logic [DW-1:0]       spram_rdata
);
    localparam int LW = $clog2(N_PORTS);
    localparam int MW = DW / 8;
    logic [0:0] state;
    logic [LW-1:0] sel, last, win, src;
    logic win_vld, grant;
    arb_rr_pick #(.N(N_PORTS)) u_pick (
        .req  (bus.req_valid),
        .last (last),
        .idx  (win),
        .vld  (win_vld)
    );
    assign grant = (state == ST_IDLE) && win_vld;
    // Outside a grant the bus is parked on port 0 (IDLE) or held on the granted port (ACK).
    assign src = grant ? win : (state == ST_ACK) ? sel : '0;
    assign spram_addr = bus.req_addr[AW*src +: AW];
    assign spram_wdata = bus.req_wdata[DW*src +: DW];
    assign spram_wmsk = bus.req_wmsk[MW*src +: MW];
    assign spram_we = grant && bus.req_we[win];
    assign bus.req_ready = (state == ST_ACK) ? N_PORTS'(1) << sel : '0;
    assign bus.req_rdata = (state == ST_ACK) ? spram_rdata : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            sel <= '0;
            last <= LW'(N_PORTS - 1);
        end else if (grant) begin
            state <= ST_ACK;
            sel <= win;
            last <= win;
        end else begin
            state <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_soc_spram_arbiter.sv
// tb_soc_spram_arbiter: directed checks of the SPRAM arbiter, 2-port and 4-port instances.
module tb_soc_spram_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [31:0] srd;
    logic [14:0] sa2, sa4;
    logic [31:0] swd2, swd4;
    logic [3:0] swm2, swm4;
    logic swe2, swe4;
    int pass = 0;
    int total = 0;

    always #5 clk = ~clk;

    soc_spram_arbiter_if #(.N_PORTS(2), .AW(15), .DW(32)) b2 ();
    soc_spram_arbiter_if #(.N_PORTS(4), .AW(15), .DW(32)) b4 ();

    soc_spram_arbiter #(.N_PORTS(2), .AW(15), .DW(32)) dut2 (
        .clk(clk), .rst(rst), .bus(b2),
        .spram_addr(sa2), .spram_wdata(swd2), .spram_wmsk(swm2),
        .spram_we(swe2), .spram_rdata(srd)
    );
    soc_spram_arbiter #(.N_PORTS(4), .AW(15), .DW(32)) dut4 (
        .clk(clk), .rst(rst), .bus(b4),
        .spram_addr(sa4), .spram_wdata(swd4), .spram_wmsk(swm4),
        .spram_we(swe4), .spram_rdata(srd)
    );

    task automatic clear_inputs();
        b2.req_addr = '0; b2.req_wdata = '0; b2.req_wmsk = '0; b2.req_we = '0; b2.req_valid = '0;
        b4.req_addr = '0; b4.req_wdata = '0; b4.req_wmsk = '0; b4.req_we = '0; b4.req_valid = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        srd = 32'hDEADBEEF;
        rst = 1'b1;
        b2.req_addr = {15'h1111, 15'h0555};
        #1;
        total++; if (b2.req_ready !== 2'b00) $display("FAIL reset_ready2: got %b want 00", b2.req_ready); else pass++;
        total++; if (b4.req_ready !== 4'b0000) $display("FAIL reset_ready4: got %b want 0000", b4.req_ready); else pass++;
        total++; if (b2.req_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", b2.req_rdata); else pass++;
        total++; if (swe2 !== 1'b0) $display("FAIL reset_we: got %b want 0", swe2); else pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (sa2 !== 15'h0555) $display("FAIL idle_park_addr: got %h want 0555", sa2); else pass++;
        total++; if (b2.req_ready !== 2'b00) $display("FAIL idle_ready: got %b want 00", b2.req_ready); else pass++;
    endtask

    task automatic test_read();
        @(negedge clk);
        b2.req_addr = {15'h0, 15'h0010};
        b2.req_we = 2'b00;
        b2.req_valid = 2'b01;
        #1;
        total++; if (sa2 !== 15'h0010) $display("FAIL read_addr: got %h want 0010", sa2); else pass++;
        total++; if (swe2 !== 1'b0) $display("FAIL read_we: got %b want 0", swe2); else pass++;
        total++; if (b2.req_ready !== 2'b00) $display("FAIL read_ready_c0: got %b want 00", b2.req_ready); else pass++;
        @(negedge clk);
        #1;
        total++; if (b2.req_ready !== 2'b01) $display("FAIL read_ready_c1: got %b want 01", b2.req_ready); else pass++;
        total++; if (b2.req_rdata !== 32'hDEADBEEF) $display("FAIL read_rdata: got %h want deadbeef", b2.req_rdata); else pass++;
        total++; if (swe2 !== 1'b0) $display("FAIL read_ack_we: got %b want 0", swe2); else pass++;
        b2.req_valid = 2'b00;
        @(negedge clk);
        #1;
        total++; if (b2.req_ready !== 2'b00) $display("FAIL read_ready_c2: got %b want 00", b2.req_ready); else pass++;
        total++; if (b2.req_rdata !== 32'h0) $display("FAIL read_rdata_c2: got %h want 0", b2.req_rdata); else pass++;
    endtask

    task automatic test_write();
        @(negedge clk);
        b2.req_addr = {15'h7FFF, 15'h0010};
        b2.req_wdata = {32'h12345678, 32'h0};
        b2.req_wmsk = {4'h0, 4'hF};
        b2.req_we = 2'b10;
        b2.req_valid = 2'b10;
        #1;
        total++; if (swe2 !== 1'b1) $display("FAIL write_we: got %b want 1", swe2); else pass++;
        total++; if (sa2 !== 15'h7FFF) $display("FAIL write_addr: got %h want 7fff", sa2); else pass++;
        total++; if (swd2 !== 32'h12345678) $display("FAIL write_data: got %h want 12345678", swd2); else pass++;
        total++; if (swm2 !== 4'h0) $display("FAIL write_mask: got %h want 0", swm2); else pass++;
        @(negedge clk);
        #1;
        total++; if (swe2 !== 1'b0) $display("FAIL write_we_c1: got %b want 0", swe2); else pass++;
        total++; if (b2.req_ready !== 2'b10) $display("FAIL write_ready: got %b want 10", b2.req_ready); else pass++;
        clear_inputs();
    endtask

    task automatic test_contention();
        logic [1:0] er;
        logic [14:0] ea;
        int exp;
        @(negedge clk);
        b2.req_addr = {15'h0200, 15'h0100};
        b2.req_valid = 2'b11;
        for (int g = 0; g < 8; g++) begin
`ifdef SOC_SPRAM_ARB_FIXED_PRIO_EN
            exp = 0;
`else
            exp = g % 2;
`endif
            er = (exp == 1) ? 2'b10 : 2'b01;
            ea = (exp == 1) ? 15'h0200 : 15'h0100;
            if (g != 0) @(negedge clk);
            #1;
            total++; if (sa2 !== ea) $display("FAIL rr_addr g%0d: got %h want %h", g, sa2, ea); else pass++;
            @(negedge clk);
            #1;
            total++; if (b2.req_ready !== er) $display("FAIL rr_ready g%0d: got %b want %b", g, b2.req_ready, er); else pass++;
        end
        b2.req_valid = 2'b10;
        @(negedge clk);
        #1;
        total++; if (sa2 !== 15'h0200) $display("FAIL rr_drop_addr: got %h want 0200", sa2); else pass++;
        @(negedge clk);
        #1;
        total++; if (b2.req_ready !== 2'b10) $display("FAIL rr_drop_ready: got %b want 10", b2.req_ready); else pass++;
        clear_inputs();
    endtask

    task automatic test_valid_drop_in_ack();
        @(negedge clk);
        b2.req_addr = {15'h0ABC, 15'h0};
        b2.req_wdata = {32'hA5A5A5A5, 32'h0};
        b2.req_we = 2'b10;
        b2.req_valid = 2'b10;
        #1;
        total++; if (swe2 !== 1'b1) $display("FAIL viol_we: got %b want 1", swe2); else pass++;
        @(negedge clk);
        b2.req_valid = 2'b00;
        #1;
        total++; if (b2.req_ready !== 2'b10) $display("FAIL viol_ready: got %b want 10", b2.req_ready); else pass++;
        total++; if (swe2 !== 1'b0) $display("FAIL viol_ack_we: got %b want 0", swe2); else pass++;
        clear_inputs();
    endtask

    task automatic test_rst_in_ack();
        srd = 32'hCAFEF00D;
        @(negedge clk);
        b2.req_addr = {15'h0, 15'h0020};
        b2.req_valid = 2'b01;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if (b2.req_ready !== 2'b00) $display("FAIL rst_ack_ready: got %b want 00", b2.req_ready); else pass++;
        total++; if (b2.req_rdata !== 32'h0) $display("FAIL rst_ack_rdata: got %h want 0", b2.req_rdata); else pass++;
        b2.req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (b2.req_ready !== 2'b00) $display("FAIL rst_release_ready: got %b want 00", b2.req_ready); else pass++;
        @(negedge clk);
        b2.req_addr = {15'h0, 15'h0030};
        b2.req_valid = 2'b01;
        #1;
        total++; if (sa2 !== 15'h0030) $display("FAIL rst_retry_addr: got %h want 0030", sa2); else pass++;
        @(negedge clk);
        #1;
        total++; if (b2.req_ready !== 2'b01) $display("FAIL rst_retry_ready: got %b want 01", b2.req_ready); else pass++;
        total++; if (b2.req_rdata !== 32'hCAFEF00D) $display("FAIL rst_retry_rdata: got %h want cafef00d", b2.req_rdata); else pass++;
        clear_inputs();
    endtask

    task automatic test_four_ports();
        logic [3:0] er;
        logic [14:0] ea;
        @(negedge clk);
        b4.req_addr = {15'h0033, 15'h0022, 15'h0011, 15'h0000};
        b4.req_valid = 4'b1010;
        #1;
        total++; if (sa4 !== 15'h0011) $display("FAIL n4_first_addr: got %h want 0011", sa4); else pass++;
        @(negedge clk);
        #1;
        total++; if (b4.req_ready !== 4'b0010) $display("FAIL n4_first_ready: got %b want 0010", b4.req_ready); else pass++;
`ifdef SOC_SPRAM_ARB_FIXED_PRIO_EN
        er = 4'b0010; ea = 15'h0011;
`else
        er = 4'b1000; ea = 15'h0033;
`endif
        @(negedge clk);
        #1;
        total++; if (sa4 !== ea) $display("FAIL n4_second_addr: got %h want %h", sa4, ea); else pass++;
        @(negedge clk);
        #1;
        total++; if (b4.req_ready !== er) $display("FAIL n4_second_ready: got %b want %b", b4.req_ready, er); else pass++;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_valid_drop_in_ack();
        test_rst_in_ack();
        test_four_ports();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
